timer_arbiter: RTL and testbench

Round-robin controller that shares a single N-bit up-counter among R requesters. Each requester asks for an interval of len+1 counts. The block grants the counter to one requester at a time, loads and runs the count, and returns a one-cycle done pulse to the owner. It sits between requesting units and the shared counting resource and drives the counter's enable and clear sequencing internally.

---
 rtl/timer_arbiter.sv | 147 ++++++++++++++
 tb/tb_timer_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner selection for one shared N-bit up-counter.
// A granted requester gets len+1 counts (q = 0..len), then a one-cycle done
// pulse while grant is still high, then the counter is released to IDLE.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req[R]    request levels, held until done or dropped (drop = abort)
//   len[R*N]  per-requester terminal count, requester i at [i*N +: N]
//   grant[R]  one-hot current owner (registered)
//   done[R]   one-cycle completion pulse to the owner (registered)
//   busy      OR of grant
//   q[N]      current count, 0 outside COUNT/REL
//   max_tick  high in COUNT while q is all ones
module timer_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] len,
  output logic [R-1:0]   grant,
  output logic [R-1:0]   done,
  output logic           busy,
  output logic [N-1:0]   q,
  output logic           max_tick
);

  localparam int RW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, REL} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] w_q, w_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  len_r_q, len_r_d;
  logic [R-1:0]  grant_q, grant_d;
  logic [R-1:0]  done_q, done_d;

  logic          win_vld;
  logic [RW-1:0] win;
  logic [RW-1:0] cand;

  function automatic logic [RW-1:0] nxt(input logic [RW-1:0] w);
    return RW'((int'(w) + 1) % R);
  endfunction

  // Scan from the farthest candidate back to ptr so the first hit after ptr
  // is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = R-1; k >= 0; k--) begin
      cand = RW'((int'(ptr_q) + k) % R);
      if (req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    len_r_d = len_r_q;
    grant_d = grant_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          state_d      = COUNT;
          w_d          = win;
          len_r_d      = len[int'(win)*N +: N];
          cnt_d        = '0;
          grant_d[win] = 1'b1;
        end
      end
      COUNT: begin
        if (!req[w_q]) begin
          // owner abandoned: release without done, still rotate past it
          state_d = IDLE;
          ptr_d   = nxt(w_q);
          cnt_d   = '0;
          grant_d = '0;
        end else if (cnt_q == len_r_q) begin
          state_d = REL;
          done_d  = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        state_d = IDLE;
        ptr_d   = nxt(w_q);
        cnt_d   = '0;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      len_r_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      len_r_q <= len_r_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only; reset clears them immediately.
  always_comb begin
    q = '0;
    case (state_q)
      COUNT:   q = cnt_q;
      REL:     q = len_r_q;
      default: q = '0;
    endcase
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = |grant_q;
  assign max_tick = (state_q == COUNT) && (cnt_q == '1);

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [R-1:0]   req;
  logic [R*N-1:0] len;
  logic [R-1:0]   grant, done;
  logic           busy, max_tick;
  logic [N-1:0]   q;

  int n_chk = 0;
  int n_err = 0;

  timer_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .len(len),
    .grant(grant), .done(done), .busy(busy), .q(q), .max_tick(max_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // packed observation: {grant, done, busy, q, max_tick}
  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                         input logic eb, input logic [3:0] eq, input logic em);
    logic [13:0] obs, exp;
    obs = {grant, done, busy, q, max_tick};
    exp = {eg, ed, eb, eq, em};
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed g=%b d=%b b=%b q=%0d mt=%b expected g=%b d=%b b=%b q=%0d mt=%b",
             tag, obs[13:10], obs[9:6], obs[5], obs[4:1], obs[0],
             eg, ed, eb, eq, em);
    end
  endtask

  initial begin
    // reset held with all requests up
    reset_n = 1'b0;
    req     = 4'hF;
    len     = '0;
    #1;
    chk_out("reset_async", 4'b0, 4'b0, 0, 0, 0);
    step(); step();
    chk_out("reset_held", 4'b0, 4'b0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    chk_out("first_grant_r0", 4'b0001, 4'b0, 1, 0, 0);
    req = 4'b0001;
    step();
    chk_out("first_done_r0", 4'b0001, 4'b0001, 1, 0, 0);
    req = 4'b0;
    step();
    chk_out("first_release", 4'b0, 4'b0, 0, 0, 0);

    // single transaction, len0 = 3 (ptr now 1, only r0 asks)
    req = 4'b0001;
    len = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("single_q%0d", i), 4'b0001, 4'b0, 1, 4'(i), 0);
    end
    step();
    chk_out("single_done", 4'b0001, 4'b0001, 1, 3, 0);
    req = 4'b0;
    step();
    chk_out("single_release", 4'b0, 4'b0, 0, 0, 0);
    step();
    chk_out("single_idle", 4'b0, 4'b0, 0, 0, 0);

    // restart pointer at 0, then full rotation with len = 0
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req = 4'hF;
    len = '0;
    for (int g = 0; g < 5; g++) begin
      step();
      chk_out($sformatf("rr%0d_count", g), 4'(1 << (g % 4)), 4'b0, 1, 0, 0);
      if (g == 4) req = 4'b0001;
      step();
      chk_out($sformatf("rr%0d_done", g), 4'(1 << (g % 4)), 4'(1 << (g % 4)), 1, 0, 0);
      if (g == 4) req = 4'b0;
      step();
      chk_out($sformatf("rr%0d_gap", g), 4'b0, 4'b0, 0, 0, 0);
    end

    // max count: len0 = 15, ptr = 1, only r0
    req = 4'b0001;
    len = 16'h000F;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_out($sformatf("max_q%0d", i), 4'b0001, 4'b0, 1, 4'(i), (i == 15));
    end
    step();
    chk_out("max_done", 4'b0001, 4'b0001, 1, 15, 0);
    req = 4'b0;
    step();
    chk_out("max_release", 4'b0, 4'b0, 0, 0, 0);

    // abort: r1 with len 7 drops at q = 2, then r0 and r2 compete (ptr = 2)
    req = 4'b0010;
    len = 16'h0070;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("abort_q%0d", i), 4'b0010, 4'b0, 1, 4'(i), 0);
    end
    req = 4'b0101;
    step();
    chk_out("abort_release", 4'b0, 4'b0, 0, 0, 0);
    step();
    chk_out("abort_next_r2", 4'b0100, 4'b0, 1, 0, 0);
    step();
    chk_out("abort_r2_done", 4'b0100, 4'b0100, 1, 0, 0);

    // reset mid-count: r0 with len 9 (ptr = 3), reset while q = 5
    req = 4'b0001;
    len = 16'h0009;
    step();
    chk_out("midrst_idle", 4'b0, 4'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    chk_out("midrst_q5", 4'b0001, 4'b0, 1, 5, 0);
    #2;
    reset_n = 1'b0;
    req     = 4'hF;
    len     = '0;
    #1;
    chk_out("midrst_async", 4'b0, 4'b0, 0, 0, 0);
    step();
    chk_out("midrst_held", 4'b0, 4'b0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    chk_out("midrst_restart_r0", 4'b0001, 4'b0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
